axil_master: RTL
================

# axil_master

AXI4-Lite single-outstanding initiator that turns a simple command/response handshake into AXI4-Lite read and write transactions. It is the other end of `axi_regfile_v1_0_S00_AXI`. Fabric-side logic, for example a boot-time configuration sequencer or a self-test block, uses it to program and read back the GPS emulator register file without the Zynq PS. It sits on `axi_aclk` next to the register file, behind an AXI interconnect or point-to-point.

## Interface
Parameters:
- `C_M_AXI_ADDR_WIDTH`, default 7: byte-address width (32 registers × 4 bytes).
- `C_M_AXI_DATA_WIDTH`, default 32: data width. Only 32 is supported.

Ports:
- `axi_aclk` in 1: the single clock.
- `axi_aresetn` in 1: reset, synchronous and active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted this cycle when both `cmd_valid` and `cmd_ready` are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_W`: byte address. Bits [1:0] are ignored and driven 0 on the bus.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write strobes.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_write` out 1: echoes `cmd_write`.
- `rsp_rdata` out 32: read data. 0 for writes.
- `rsp_resp` out 2: the captured BRESP or RRESP.
- `M_AXI_AWADDR` out `ADDR_W`; `M_AXI_AWPROT` out 3; `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32; `M_AXI_WSTRB` out 4; `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out `ADDR_W`; `M_AXI_ARPROT` out 3; `M_AXI_ARVALID` out 1; `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32; `M_AXI_RRESP` in 2; `M_AXI_RVALID` in 1; `M_AXI_RREADY` out 1.

## Operation
- **States:** IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- **IDLE:**
  - `cmd_ready` = 1.
  - On accept, address, data and strobe are registered.
  - Go to WR_ADDR_DATA if `cmd_write`, else RD_ADDR.
- **WR_ADDR_DATA:**
  - AWVALID and WVALID are asserted together.
  - Each drops independently after its own handshake, tracked by `aw_done` and `w_done` flags.
  - When both are done, go to WR_RESP. A same-cycle handshake on both channels goes directly to WR_RESP.
- **WR_RESP:** BREADY = 1. On BVALID, capture BRESP and go to RSP.
- **RD_ADDR:** ARVALID = 1. On ARREADY, go to RD_DATA.
- **RD_DATA:** RREADY = 1. On RVALID, capture RDATA and RRESP and go to RSP.
- **RSP:**
  - `rsp_valid` = 1, and all `rsp_*` fields are held stable.
  - On `rsp_ready`, return to IDLE.
- **Outstanding limit:** exactly one transaction at a time. `cmd_ready` = 0 in every state except IDLE.
- **PROT:** AWPROT and ARPROT are constant 3'b000.
- **AXI payload stability:** all payloads are registered and remain stable while VALID is high. No VALID depends combinationally on a READY.
- **Errors:** SLVERR and DECERR are reported verbatim in `rsp_resp`. No retry.

## Timing
- **Reset:** while `axi_aresetn` = 0 at a rising edge:
  - state becomes IDLE;
  - all VALID, BREADY and RREADY outputs are 0;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_resp` = 0, `rsp_write` = 0;
  - address and data outputs are 0;
  - `cmd_ready` is forced to 0 during reset cycles.
- **Reset mid-transaction:** the transaction is abandoned and no response is produced. The next edge with reset high sits in IDLE.
- **Write, zero-wait slave:**
  - cycle 0: command accept;
  - cycle 1: AWVALID and WVALID high, both handshakes complete;
  - cycle 2: BREADY high, BVALID handshake;
  - cycle 3: `rsp_valid` high.
  - Latency from accept to `rsp_valid` is 3 cycles minimum.
- **Read, zero-wait slave:**
  - cycle 1: ARVALID handshake;
  - cycle 2: R handshake;
  - cycle 3: `rsp_valid` high.
  - Latency is 3 cycles minimum.
- **Back-to-back:** `rsp_ready` high on the first RSP cycle returns the block to IDLE on the next cycle. The next command can therefore be accepted 1 cycle after the response handshake. Throughput is at best one transaction per 4 cycles.
- **Early response:**
  - BVALID or RVALID arriving before this block reaches the state that asserts BREADY or RREADY is simply waited for.
  - The slave must not issue B before both AW and W handshakes, per AXI rules.
- **Stalled handshakes:** an unbounded stall on any channel holds the corresponding state indefinitely. There is no timeout.

## Structure
- **Package `axil_pkg`:**
  - `axil_state_t` enum covering the six states;
  - response constants `AXI_OKAY`=2'b00, `AXI_EXOKAY`=2'b01, `AXI_SLVERR`=2'b10, `AXI_DECERR`=2'b11;
  - `AXI_PROT_DEFAULT`=3'b000.
- **Module layout:** a single module, one `always_ff` for state and registers plus combinational decode of `cmd_ready`. No sub-module is needed.
- **Bench:** instantiates `axil_master` against the existing register file with an AXI-Lite protocol checker.

## Test plan
- **Write then read reg 6:** write 0x0000_0001 to address 0x18 with wstrb 0xF, then read 0x18 → both `rsp_resp` = 0. Read gives `rsp_rdata` = 0x0000_0001.
- **Constant register:** read address 0x00 → `rsp_rdata` = 0xDEADBEEF; read address 0x04 → `rsp_rdata` = 0x7654_3210. Both `rsp_resp` = 0.
- **AW/W skew:** slave model holds AWREADY low for 3 cycles while WREADY is immediate → WVALID drops after 1 cycle, AWVALID stays high for 4 cycles, exactly one B handshake, one response.
- **Response backpressure:** `rsp_ready` held low for 5 cycles after `rsp_valid` rises → `rsp_*` stable for all 6 cycles, `cmd_ready` = 0 throughout, IDLE on the cycle after handshake.
- **Error response:** slave model returns BRESP = 2'b10 → `rsp_resp` = 2'b10, `rsp_write` = 1, `rsp_rdata` = 0.
- **Reset mid-op:** assert `axi_aresetn` = 0 for 1 cycle while in WR_RESP → next cycle all VALID and READY outputs are 0, no `rsp_valid` ever appears for that command, and a new command is accepted after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite command/response initiator.
`timescale 1ns/1ps
package axil_pkg;

  // One state per protocol phase; a single transaction is in flight at a time.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } axil_state_t;

  // AXI response codes, passed through to rsp_resp unchanged.
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite single-outstanding initiator: turns a cmd/rsp handshake into
// one AXI4-Lite read or write transaction at a time.
//
// Handshake semantics (all channels, command and response side alike):
// a transfer happens on a rising edge where VALID and READY are both high.
// VALID never depends combinationally on READY, and every payload is held in
// a register so it stays stable for as long as its VALID is high.
`timescale 1ns/1ps
module axil_master
  import axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  // command side
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response side
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  // AXI write address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // AXI write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // AXI write response
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // AXI read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // AXI read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  // debug visibility of the protocol FSM
  output axil_state_t                       dbg_state_o
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  // Word alignment: the two byte-offset bits never reach the bus.
  localparam logic [AW-1:0] ADDR_LSB_MASK = AW'(3);

  axil_state_t   state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          write_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    resp_q;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q,  w_done_d;

  logic          cmd_hs;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;

  assign cmd_hs = cmd_valid     & cmd_ready;
  assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID  & M_AXI_RREADY;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // AW and W complete independently; a flag remembers each finished channel.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (cmd_hs) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end
  end

  // Next-state decode: advance only on the handshake that ends each phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) state_d = RSP;
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) state_d = RSP;
      end
      RSP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: VALID/READY strobes come from state and done flags only.
  always_comb begin
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      IDLE:         cmd_ready     = axi_aresetn;
      WR_ADDR_DATA: begin
        M_AXI_AWVALID = ~aw_done_q;
        M_AXI_WVALID  = ~w_done_q;
      end
      WR_RESP:      M_AXI_BREADY  = 1'b1;
      RD_ADDR:      M_AXI_ARVALID = 1'b1;
      RD_DATA:      M_AXI_RREADY  = 1'b1;
      RSP:          rsp_valid     = 1'b1;
      default:      ;
    endcase
  end

  // Payload and response capture; everything here is stable between events.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXI_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (cmd_hs) begin
        addr_q  <= cmd_addr & ~ADDR_LSB_MASK;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        // Writes report zero read data, so clear it up front.
        rdata_q <= '0;
        resp_q  <= AXI_OKAY;
      end
      if (state_q == WR_RESP && b_hs) begin
        resp_q <= M_AXI_BRESP;
      end
      if (state_q == RD_DATA && r_hs) begin
        rdata_q <= M_AXI_RDATA;
        resp_q  <= M_AXI_RRESP;
      end
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;

  assign rsp_write    = write_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

  assign dbg_state_o  = state_q;

endmodule
